b16_debug: RTL and testbench
============================

B16_DEBUG -- requirements
Module: b16_debug

Interface
REQ-001 SHALL have parameter L, 16, data/address width.
REQ-002 SHALL have parameter NBP, 4, breakpoint count (1..4).
REQ-003 SHALL have parameter DBGADDR, 11'h7FF, debug window base (compared with addr[L-1:5]).
REQ-004 SHALL have parameter STEPW, 8, step counter width.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port addr  input  L-1  host word address [L-1:1].
REQ-008 SHALL have port data  input  L  host write data.
REQ-009 SHALL have port r  input  1  host read strobe.
REQ-010 SHALL have port w  input  2  host byte write strobes.
REQ-011 SHALL have port cpu_addr  input  L  CPU bus address.
REQ-012 SHALL have port cpu_r  input  1  CPU read/fetch.
REQ-013 SHALL have port cpu_wr  input  2  CPU byte writes.
REQ-014 SHALL have port cpu_run  input  1  CPU advanced this cycle.
REQ-015 SHALL have port drun  output  1  CPU run enable.
REQ-016 SHALL have port dr  output  1  CPU debug-port read (window words 0-7).
REQ-017 SHALL have port dw  output  1  CPU debug-port write (window words 0-7).
REQ-018 SHALL have port rdata  output  L  local register read data, 0 when not selected.
REQ-019 SHALL have port hit  output  1  one-cycle pulse on breakpoint halt.

Function
REQ-020 SHALL select the window when addr[L-1:5]==DBGADDR; word index addr[4:1].
REQ-021 SHALL decode words 0-7 combinationally as dr=sel&r, dw=sel&|w, with daddr being addr[3:1].
REQ-022 SHALL map local words: 8 CTRL/STATUS, 9 STEP, 10 BPCFG, 11 CYCLES, 12+k BPk address (k<NBP).
REQ-023 SHALL drive rdata combinationally from the selected local word; words >=12+NBP SHALL read 0.
REQ-024 SHALL implement FSM states RUN, STEP, HALT; drun=1 in RUN and STEP, drun registered.
REQ-025 SHALL decode CTRL write bit0 (go) in HALT: go SHALL move the FSM to RUN when STEP==0, else to STEP with the counter loaded from STEP.
REQ-026 SHALL decode CTRL write bit1 (halt) from any state: halt SHALL move the FSM to HALT with cause HOST.
REQ-027 SHALL decrement the step counter in STEP on each cpu_run cycle; reaching 0 SHALL move the FSM to HALT with cause STEP.
REQ-028 SHALL define an enabled BPk hit as: cpu_addr==BPk and (type 0: cpu_r; type 1: |cpu_wr), sampled when cpu_run=1.
REQ-029 SHALL move the FSM from RUN/STEP to HALT on a hit, with cause BP and index = lowest hitting k; drun=0 and hit=1 the following cycle.
REQ-030 SHALL mask hits for the first cpu_run cycle after leaving HALT, so resume from a breakpoint address proceeds.
REQ-031 SHALL give a simultaneous host CTRL write priority over a hit or step expiry.
REQ-032 SHALL lay out STATUS read as: bit15 drun, [14:13] state, [12:11] cause (0 none, 1 HOST, 2 BP, 3 STEP), [9:8] bp index.
REQ-033 SHALL define BPCFG as [3:0] enable, [7:4] type; bits >=NBP SHALL read 0.
REQ-034 SHALL define CYCLES as a 16-bit counter that increments on cpu_run, wraps FFFF->0000, and clears on any write.
REQ-035 SHALL make a STEP write of 0 followed by go equivalent to a free run.

Reset
REQ-036 SHALL on reset set state RUN, drun=1, cause 0, BPCFG 0, BPk FFFF, STEP 0, CYCLES 0, hit 0.
REQ-037 SHALL on reset mid-STEP abandon the remaining count immediately.

Configuration
REQ-038 SHALL compile write watchpoints (type 1) in with B16_DBG_WATCH_EN defined.
REQ-039 SHALL without B16_DBG_WATCH_EN make BPCFG[7:4] read 0, treat all breakpoints as type 0, and ignore cpu_wr.

Structure
REQ-040 SHALL place word indices, cause codes, and the FSM state encoding in package b16_dbg_pkg.
REQ-041 SHALL use sub-module b16_bp_match (one comparator per breakpoint, type/enable qualified), instantiated NBP times.

Verification
REQ-042 SHALL verify: BP0=0x0100, BPCFG=0x0001, fetch at 0x0100 -> hit pulse, drun=0 next cycle, STATUS cause=2 index 0.
REQ-043 SHALL verify: from REQ-042 state, CTRL=1 with STEP=0 -> drun=1, fetch 0x0100 is not re-trapped, run continues.
REQ-044 SHALL verify: STEP=3, go -> exactly 3 cpu_run cycles, then HALT with cause=3.
REQ-045 SHALL verify: BP1=0x2000, BPCFG=0x0022, CPU write w=01 to 0x2000 -> halt, index 1; without B16_DBG_WATCH_EN -> no halt.
REQ-046 SHALL verify: host CTRL=2 in the same cycle as a BP hit -> cause=1 (HOST).
REQ-047 SHALL verify: CYCLES preset near FFFF wraps to 0000; reset asserted mid-STEP -> state RUN, all registers at reset values.

Source files
------------

// File: rtl/b16_dbg_pkg.sv
// Shared definitions for the b16 debug unit: local word map, halt-cause codes
// and the run-control FSM encoding.
package b16_dbg_pkg;

    localparam logic [3:0] W_CTRL   = 4'd8;
    localparam logic [3:0] W_STEP   = 4'd9;
    localparam logic [3:0] W_BPCFG  = 4'd10;
    localparam logic [3:0] W_CYCLES = 4'd11;
    localparam logic [3:0] W_BP0    = 4'd12;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_HOST = 2'd1;
    localparam logic [1:0] C_BP   = 2'd2;
    localparam logic [1:0] C_STEP = 2'd3;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_STEP = 2'd1,
        S_HALT = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/b16_bp_match.sv
// Single breakpoint comparator: address equality qualified by enable, access
// type (0 = read/fetch, 1 = write) and the sample strobe.
module b16_bp_match #(
    parameter int L = 16
) (
    input  logic         en,
    input  logic         typ,
    input  logic [L-1:0] bp,
    input  logic [L-1:0] cpu_addr,
    input  logic         cpu_r,
    input  logic         cpu_w,
    input  logic         sample,
    output logic         match
);

    assign match = sample && en && (cpu_addr == bp) && (typ ? cpu_w : cpu_r);

endmodule

// File: rtl/b16_debug.sv
// b16 debug unit: host-visible run control (RUN/STEP/HALT), breakpoints, step
// and cycle counters. Define B16_DBG_WATCH_EN to build in write watchpoints.
module b16_debug
    import b16_dbg_pkg::*;
#(
    parameter int             L       = 16,
    parameter int             NBP     = 4,
    parameter logic [L-6:0]   DBGADDR = 11'h7FF,
    parameter int             STEPW   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [L-1:1] addr,
    input  logic [L-1:0] data,
    input  logic         r,
    input  logic [1:0]   w,
    input  logic [L-1:0] cpu_addr,
    input  logic         cpu_r,
    input  logic [1:0]   cpu_wr,
    input  logic         cpu_run,
    output logic         drun,
    output logic         dr,
    output logic         dw,
    output logic [2:0]   daddr,
    output logic [L-1:0] rdata,
    output logic         hit
);

    function automatic logic [L-1:0] bmerge(input logic [L-1:0] old,
                                             input logic [L-1:0] nw,
                                             input logic [1:0]   be);
        bmerge = old;
        if (be[0]) bmerge[7:0]   = nw[7:0];
        if (be[1]) bmerge[L-1:8] = nw[L-1:8];
    endfunction

    dbg_state_t       state, state_n;
    logic [1:0]       cause, cause_n;
    logic [1:0]       bpidx, bpidx_n;
    logic [STEPW-1:0] step_r, stepcnt, cnt_n;
    logic [15:0]      cycles;
    logic             mask, mask_n, hit_n;
    logic [NBP-1:0]   bp_en, bp_typ, m;
    logic [L-1:0]     bp [NBP];
    logic             cpu_w;
    logic             any_hit;
    logic [1:0]       hit_idx;

    logic       sel, lwr, wr_ctrl;
    logic [3:0] widx;

    assign sel     = (addr[L-1:5] == DBGADDR);
    assign widx    = addr[4:1];
    assign daddr   = addr[3:1];
    assign dr      = sel && !widx[3] && r;
    assign dw      = sel && !widx[3] && (|w);
    assign lwr     = sel && widx[3] && (|w);
    assign wr_ctrl = lwr && (widx == W_CTRL) && w[0];

`ifdef B16_DBG_WATCH_EN
    assign cpu_w = |cpu_wr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bp_typ <= '0;
        else if (lwr && widx == W_BPCFG && w[0])
            bp_typ <= data[4 +: NBP];
    end
`else
    // Watchpoints compiled out: every breakpoint behaves as a fetch breakpoint.
    logic unused_cpu_wr;
    assign unused_cpu_wr = ^cpu_wr;
    assign cpu_w  = 1'b0;
    assign bp_typ = '0;
`endif

    for (genvar k = 0; k < NBP; k++) begin : g_bp
        b16_bp_match #(.L(L)) u_match (
            .en       (bp_en[k]),
            .typ      (bp_typ[k]),
            .bp       (bp[k]),
            .cpu_addr (cpu_addr),
            .cpu_r    (cpu_r),
            .cpu_w    (cpu_w),
            .sample   (cpu_run && !mask),
            .match    (m[k])
        );
    end

    always_comb begin
        any_hit = 1'b0;
        hit_idx = 2'd0;
        for (int k = NBP - 1; k >= 0; k--) begin
            if (m[k]) begin
                any_hit = 1'b1;
                hit_idx = 2'(k);
            end
        end
    end

    // Host halt beats go; host CTRL beats a breakpoint, which beats step expiry.
    always_comb begin
        state_n = state;
        cause_n = cause;
        bpidx_n = bpidx;
        cnt_n   = stepcnt;
        mask_n  = mask;
        hit_n   = 1'b0;
        if (cpu_run) mask_n = 1'b0;
        if (cpu_run && state == S_STEP) cnt_n = stepcnt - STEPW'(1);
        if (wr_ctrl && data[1]) begin
            state_n = S_HALT;
            cause_n = C_HOST;
        end else if (wr_ctrl && data[0] && state == S_HALT) begin
            state_n = (step_r == '0) ? S_RUN : S_STEP;
            cnt_n   = step_r;
            cause_n = C_NONE;
            mask_n  = 1'b1;
        end else if (state != S_HALT && any_hit) begin
            state_n = S_HALT;
            cause_n = C_BP;
            bpidx_n = hit_idx;
            hit_n   = 1'b1;
        end else if (state == S_STEP && cpu_run && stepcnt == STEPW'(1)) begin
            state_n = S_HALT;
            cause_n = C_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_RUN;
            cause   <= C_NONE;
            bpidx   <= 2'd0;
            stepcnt <= '0;
            mask    <= 1'b0;
            drun    <= 1'b1;
            hit     <= 1'b0;
            step_r  <= '0;
            cycles  <= 16'd0;
            bp_en   <= '0;
            for (int k = 0; k < NBP; k++) bp[k] <= '1;
        end else begin
            state   <= state_n;
            cause   <= cause_n;
            bpidx   <= bpidx_n;
            stepcnt <= cnt_n;
            mask    <= mask_n;
            drun    <= (state_n != S_HALT);
            hit     <= hit_n;
            if (lwr && widx == W_STEP)
                step_r <= STEPW'(bmerge(L'(step_r), data, w));
            if (lwr && widx == W_CYCLES)
                cycles <= 16'd0;
            else if (cpu_run)
                cycles <= cycles + 16'd1;
            if (lwr && widx == W_BPCFG && w[0])
                bp_en <= data[NBP-1:0];
            for (int k = 0; k < NBP; k++)
                if (lwr && widx == W_BP0 + 4'(k))
                    bp[k] <= bmerge(bp[k], data, w);
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && widx[3]) begin
            case (widx)
                W_CTRL:   rdata = L'({drun, state, cause, 1'b0, bpidx, 8'h00});
                W_STEP:   rdata = L'(step_r);
                W_BPCFG: begin
                    rdata[NBP-1:0]   = bp_en;
                    rdata[4 +: NBP]  = bp_typ;
                end
                W_CYCLES: rdata = L'(cycles);
                default: begin
                    for (int k = 0; k < NBP; k++)
                        if (widx == W_BP0 + 4'(k)) rdata = bp[k];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b16_debug.sv
// Directed bench for b16_debug: a decode/readback vector table after reset,
// then hand-written run-control sequences for breakpoints, stepping and counters.
module tb_b16_debug;

`ifdef B16_DBG_WATCH_EN
    localparam bit WATCH = 1'b1;
`else
    localparam bit WATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:1] addr = '0;
    logic [15:0] data = '0;
    logic        r = 1'b0;
    logic [1:0]  w = 2'b00;
    logic [15:0] cpu_addr = '0;
    logic        cpu_r = 1'b0;
    logic [1:0]  cpu_wr = 2'b00;
    logic        cpu_run = 1'b0;
    logic        drun, dr, dw, hit;
    logic [2:0]  daddr;
    logic [15:0] rdata;

    int nvec = 0;
    int nerr = 0;

    b16_debug dut (
        .clk(clk), .reset(reset), .addr(addr), .data(data), .r(r), .w(w),
        .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_wr(cpu_wr), .cpu_run(cpu_run),
        .drun(drun), .dr(dr), .dw(dw), .daddr(daddr), .rdata(rdata), .hit(hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] base;
        logic [3:0]  word;
        logic        r;
        logic [1:0]  w;
        logic        exp_dr;
        logic        exp_dw;
        logic [2:0]  exp_daddr;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [3:0] word, input logic [15:0] val, input logic [1:0] be);
        addr = {11'h7FF, word};
        data = val;
        w    = be;
        step();
        w    = 2'b00;
        addr = '0;
    endtask

    task automatic host_rd(input logic [3:0] word, output logic [15:0] got);
        addr = {11'h7FF, word};
        r    = 1'b1;
        #1;
        got  = rdata;
        r    = 1'b0;
        addr = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] word, input logic [15:0] exp);
        logic [15:0] got;
        host_rd(word, got);
        chk(nm, 32'(got), 32'(exp));
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rd, input logic [1:0] wr);
        cpu_addr = a;
        cpu_r    = rd;
        cpu_wr   = wr;
        cpu_run  = 1'b1;
        step();
        cpu_r    = 1'b0;
        cpu_wr   = 2'b00;
        cpu_run  = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{11'h7FF, 4'd0,  1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 16'h0000};
        tbl[1] = '{11'h7FF, 4'd5,  1'b0, 2'b10, 1'b0, 1'b1, 3'd5, 16'h0000};
        tbl[2] = '{11'h7FF, 4'd7,  1'b1, 2'b01, 1'b1, 1'b1, 3'd7, 16'h0000};
        tbl[3] = '{11'h7FF, 4'd8,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 16'h8000};
        tbl[4] = '{11'h7FF, 4'd9,  1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 16'h0000};
        tbl[5] = '{11'h7FF, 4'd10, 1'b1, 2'b00, 1'b0, 1'b0, 3'd2, 16'h0000};
        tbl[6] = '{11'h7FF, 4'd12, 1'b1, 2'b00, 1'b0, 1'b0, 3'd4, 16'hFFFF};
        tbl[7] = '{11'h7FF, 4'd15, 1'b1, 2'b00, 1'b0, 1'b0, 3'd7, 16'hFFFF};
        tbl[8] = '{11'h7FE, 4'd0,  1'b1, 2'b11, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[9] = '{11'h3FF, 4'd8,  1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 16'h0000};

        repeat (3) step();
        chk("reset drun", 32'(drun), 32'd1);
        chk("reset hit", 32'(hit), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            addr = {tbl[i].base, tbl[i].word};
            r    = tbl[i].r;
            w    = tbl[i].w;
            #1;
            chk($sformatf("tbl%0d dr", i), 32'(dr), 32'(tbl[i].exp_dr));
            chk($sformatf("tbl%0d dw", i), 32'(dw), 32'(tbl[i].exp_dw));
            chk($sformatf("tbl%0d daddr", i), 32'(daddr), 32'(tbl[i].exp_daddr));
            chk($sformatf("tbl%0d rdata", i), 32'(rdata), 32'(tbl[i].exp_rdata));
            r = 1'b0;
            w = 2'b00;
            addr = '0;
        end

        // Breakpoint on fetch of 0x0100
        host_wr(4'd12, 16'h0100, 2'b11);
        host_wr(4'd10, 16'h0001, 2'b01);
        rd_chk("bp0 readback", 4'd12, 16'h0100);
        rd_chk("bpcfg readback", 4'd10, 16'h0001);
        cpu_cycle(16'h0100, 1'b0, 2'b01);
        chk("type0 ignores write", 32'(hit), 32'd0);
        cpu_cycle(16'h0102, 1'b1, 2'b00);
        chk("other fetch no hit", 32'(drun), 32'd1);
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        chk("bp hit pulse", 32'(hit), 32'd1);
        chk("bp drun low", 32'(drun), 32'd0);
        rd_chk("bp status", 4'd8, 16'h5000);
        step();
        chk("hit one cycle", 32'(hit), 32'd0);

        // Resume with STEP=0: first fetch at the breakpoint is not re-trapped
        host_wr(4'd8, 16'h0001, 2'b01);
        chk("go drun", 32'(drun), 32'd1);
        rd_chk("go status", 4'd8, 16'h8000);
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        chk("resume masked", 32'(hit), 32'd0);
        cpu_cycle(16'h0102, 1'b1, 2'b00);
        chk("resume running", 32'(drun), 32'd1);
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        chk("re-arm hit", 32'(hit), 32'd1);

        // Single-step 3 cpu_run cycles with an idle cycle in between
        host_wr(4'd9, 16'h0003, 2'b01);
        host_wr(4'd8, 16'h0001, 2'b01);
        rd_chk("step status", 4'd8, 16'hA000);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) step();
            else begin
                cpu_cycle(16'h0200, 1'b1, 2'b00);
                n++;
            end
            if (!drun) break;
        end
        chk("step run count", 32'(n), 32'd3);
        chk("step no hit pulse", 32'(hit), 32'd0);
        rd_chk("step expiry status", 4'd8, 16'h5800);

        // Write watchpoint on BP1
        host_wr(4'd9, 16'h0000, 2'b01);
        host_wr(4'd13, 16'h2000, 2'b11);
        host_wr(4'd10, 16'h0022, 2'b01);
        rd_chk("bpcfg type bits", 4'd10, WATCH ? 16'h0022 : 16'h0002);
        host_wr(4'd8, 16'h0001, 2'b01);
        cpu_cycle(16'h0300, 1'b1, 2'b00);
        cpu_cycle(16'h2000, 1'b0, 2'b01);
        chk("watch hit", 32'(hit), WATCH ? 32'd1 : 32'd0);
        rd_chk("watch status", 4'd8, WATCH ? 16'h5100 : 16'h8000);
        host_wr(4'd8, 16'h0002, 2'b01);
        host_wr(4'd8, 16'h0001, 2'b01);
        cpu_cycle(16'h0300, 1'b1, 2'b00);
        cpu_cycle(16'h2000, 1'b1, 2'b00);
        chk("bp1 fetch", 32'(hit), WATCH ? 32'd0 : 32'd1);

        // Host halt in the same cycle as a breakpoint hit
        host_wr(4'd8, 16'h0002, 2'b01);
        host_wr(4'd8, 16'h0001, 2'b01);
        cpu_cycle(16'h0300, 1'b1, 2'b00);
        host_wr(4'd10, 16'h0001, 2'b01);
        addr = {11'h7FF, 4'd8};
        data = 16'h0002;
        w    = 2'b01;
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        w    = 2'b00;
        addr = '0;
        chk("host vs bp hit", 32'(hit), 32'd0);
        chk("host vs bp drun", 32'(drun), 32'd0);
        rd_chk("host vs bp status", 4'd8, 16'h4900);

        // Two breakpoints on one address: lowest index reported
        host_wr(4'd8, 16'h0001, 2'b01);
        cpu_cycle(16'h0300, 1'b1, 2'b00);
        host_wr(4'd13, 16'h0100, 2'b11);
        host_wr(4'd10, 16'h0003, 2'b01);
        cpu_cycle(16'h0100, 1'b1, 2'b00);
        chk("dual hit", 32'(hit), 32'd1);
        rd_chk("dual hit status", 4'd8, 16'h5000);

        // CYCLES clear on write and wrap
        host_wr(4'd11, 16'h1234, 2'b11);
        rd_chk("cycles cleared", 4'd11, 16'h0000);
        cpu_addr = 16'h0400;
        cpu_run  = 1'b1;
        repeat (65533) step();
        cpu_run  = 1'b0;
        rd_chk("cycles near top", 4'd11, 16'hFFFD);
        cpu_run  = 1'b1;
        repeat (2) step();
        cpu_run  = 1'b0;
        rd_chk("cycles max", 4'd11, 16'hFFFF);
        cpu_run  = 1'b1;
        step();
        cpu_run  = 1'b0;
        rd_chk("cycles wrap", 4'd11, 16'h0000);

        // Reset in the middle of a step sequence
        host_wr(4'd9, 16'h0005, 2'b01);
        host_wr(4'd8, 16'h0001, 2'b01);
        cpu_cycle(16'h0400, 1'b1, 2'b00);
        cpu_cycle(16'h0400, 1'b1, 2'b00);
        rd_chk("mid step status", 4'd8, 16'hA000);
        reset = 1'b0;
        #1;
        chk("rst drun", 32'(drun), 32'd1);
        chk("rst hit", 32'(hit), 32'd0);
        rd_chk("rst status", 4'd8, 16'h8000);
        rd_chk("rst step", 4'd9, 16'h0000);
        rd_chk("rst bpcfg", 4'd10, 16'h0000);
        rd_chk("rst cycles", 4'd11, 16'h0000);
        for (int k = 0; k < 4; k++)
            rd_chk($sformatf("rst bp%0d", k), 4'(12 + k), 16'hFFFF);
        step();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cpu_cycle(16'h0400, 1'b1, 2'b00);
            if (!drun) n++;
        end
        chk("step abandoned", 32'(n), 32'd0);
        rd_chk("post reset status", 4'd8, 16'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
